// File: rtl/temp_alarm_pkg.sv
// temp_alarm_pkg: shared class/state encodings and the flag-priority classifier
package temp_alarm_pkg;
    typedef logic [1:0] temp_class_t;
    localparam temp_class_t ST_OK   = 2'd0;
    localparam temp_class_t ST_WARN = 2'd1;
    localparam temp_class_t ST_COLD = 2'd2;
    localparam temp_class_t ST_CRIT = 2'd3;
    function automatic temp_class_t classify(input logic temp_state, input logic temp_low, input logic temp_high);
        return temp_state ? ST_CRIT : temp_low ? ST_COLD : temp_high ? ST_WARN : ST_OK;
    endfunction
endpackage

// File: rtl/temp_class_debounce.sv
// temp_class_debounce: tracks the run of identical valid-sample classes
module temp_class_debounce
    import temp_alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  temp_class_t sample_class,
    output temp_class_t qualified_class,
    output logic        qualified_valid
);
    localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES);
    temp_class_t candidate, candidate_next;
    logic [7:0] count, count_next;
    always_comb begin
        candidate_next = sample_valid ? sample_class : candidate;
        count_next = !sample_valid ? count :
                     sample_class != candidate ? 8'd1 :
                     count == LIMIT ? count : count + 8'd1;
    end
    // Qualification reflects the post-update run so the FSM moves on the Nth sample's edge
    assign qualified_class = candidate_next;
    assign qualified_valid = sample_valid && count_next >= LIMIT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate <= ST_OK;
            count     <= 8'd0;
        end else begin
            candidate <= candidate_next;
            count     <= count_next;
        end
    end
endmodule

// File: rtl/temp_alarm_ctrl.sv
// temp_alarm_ctrl: debounced temperature alarm FSM with sticky alarm and fault counter
module temp_alarm_ctrl
    import temp_alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic             temp_high,
    input  logic             temp_state,
    input  logic             temp_low,
    input  logic             alarm_ack,
    output logic [1:0]       state_out,
    output logic             warn,
    output logic             cold,
    output logic             critical,
    output logic             alarm_latched,
    output logic [CNT_W-1:0] event_count
);
    temp_class_t state, qualified_class;
    logic qualified_valid, enter, enter_fault;
    temp_class_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_valid   (sample_valid),
        .sample_class   (classify(temp_state, temp_low, temp_high)),
        .qualified_class(qualified_class),
        .qualified_valid(qualified_valid)
    );
    assign enter       = qualified_valid && qualified_class != state;
    assign enter_fault = enter && (qualified_class == ST_CRIT || qualified_class == ST_COLD);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_OK;
            alarm_latched <= 1'b0;
            event_count   <= '0;
        end else begin
            if (enter)
                state <= qualified_class;
            if (enter && qualified_class == ST_CRIT)
                alarm_latched <= 1'b1;
            else if (alarm_ack && state != ST_CRIT)
                alarm_latched <= 1'b0;
            if (enter_fault && event_count != '1)
                event_count <= event_count + CNT_W'(1);
        end
    end
    assign state_out = state;
    assign warn      = state == ST_WARN;
    assign cold      = state == ST_COLD;
    assign critical  = state == ST_CRIT;
endmodule

// File: tb/tb_temp_alarm_ctrl.sv
// tb_temp_alarm_ctrl: directed plus randomized checks against a sample-history reference model
module tb_temp_alarm_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic sample_valid = 1'b0, temp_high = 1'b0, temp_state = 1'b0, temp_low = 1'b0, alarm_ack = 1'b0;
    logic [1:0] state_out, state_out2;
    logic warn, cold, critical, alarm_latched;
    logic warn2, cold2, critical2, alarm_latched2;
    logic [7:0] event_count;
    logic [1:0] event_count2;
    int vectors = 0, miscompares = 0;
    int m_state = 0, m_alarm = 0, m_events = 0;
    int hist[$];

    always #5 clk = ~clk;

    temp_alarm_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .temp_high(temp_high),
        .temp_state(temp_state), .temp_low(temp_low), .alarm_ack(alarm_ack),
        .state_out(state_out), .warn(warn), .cold(cold), .critical(critical),
        .alarm_latched(alarm_latched), .event_count(event_count));

    temp_alarm_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .temp_high(temp_high),
        .temp_state(temp_state), .temp_low(temp_low), .alarm_ack(alarm_ack),
        .state_out(state_out2), .warn(warn2), .cold(cold2), .critical(critical2),
        .alarm_latched(alarm_latched2), .event_count(event_count2));

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, int'(state_out), m_state);
        chk({tag, ".warn"}, int'(warn), int'(m_state == 1));
        chk({tag, ".cold"}, int'(cold), int'(m_state == 2));
        chk({tag, ".critical"}, int'(critical), int'(m_state == 3));
        chk({tag, ".alarm"}, int'(alarm_latched), m_alarm);
        chk({tag, ".events8"}, int'(event_count), m_events > 255 ? 255 : m_events);
        chk({tag, ".state2"}, int'(state_out2), m_state);
        chk({tag, ".alarm2"}, int'(alarm_latched2), m_alarm);
        chk({tag, ".events2"}, int'(event_count2), m_events > 3 ? 3 : m_events);
    endtask

    function automatic void model_reset();
        hist.delete();
        m_state = 0;
        m_alarm = 0;
        m_events = 0;
    endfunction

    // A transition happens when the last four valid samples all share a class differing from the state
    function automatic void model_step(input bit v, input bit th, input bit ts, input bit tl, input bit ack);
        int cls;
        bit run, entering_crit;
        cls = ts ? 3 : tl ? 2 : th ? 1 : 0;
        entering_crit = 0;
        if (v) begin
            hist.push_back(cls);
            if (hist.size() > 4) void'(hist.pop_front());
            run = hist.size() == 4;
            foreach (hist[i]) if (hist[i] != cls) run = 0;
            if (run && cls != m_state) begin
                if (cls >= 2) m_events++;
                entering_crit = cls == 3;
                if (entering_crit) m_alarm = 1;
                m_state = cls;
                if (entering_crit) return;
            end
        end
        if (ack && !entering_crit && m_state != 3 && !(v && m_state == 3)) m_alarm = 0;
    endfunction

    task automatic step(input string tag, input bit v, input bit th, input bit ts, input bit tl, input bit ack);
        int prev_state;
        sample_valid = v; temp_high = th; temp_state = ts; temp_low = tl; alarm_ack = ack;
        prev_state = m_state;
        model_step(v, th, ts, tl, ack);
        if (ack && prev_state == 3 && m_state != 3) m_alarm = 1;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic repeat_step(input string tag, input int n, input bit th, input bit ts, input bit tl);
        for (int i = 0; i < n; i++) step(tag, 1'b1, th, ts, tl, 1'b0);
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        repeat_step("deb_pre", 3, 0, 1, 0);
        step("deb_break", 1, 0, 0, 0, 0);
        repeat_step("deb_run", 3, 0, 1, 0);
        chk("deb_no_trip", int'(state_out), 0);
        step("deb_trip", 1, 0, 1, 0, 0);
        chk("deb_crit_state", int'(state_out), 3);
        chk("deb_crit_alarm", int'(alarm_latched), 1);
        chk("deb_crit_events", int'(event_count), 1);

        step("ack_in_crit", 1, 0, 1, 0, 1);
        chk("ack_ignored", int'(alarm_latched), 1);
        repeat_step("exit_ok", 4, 0, 0, 0);
        chk("exit_state", int'(state_out), 0);
        chk("exit_alarm_sticky", int'(alarm_latched), 1);
        step("ack_clear", 0, 0, 0, 0, 1);
        chk("ack_cleared", int'(alarm_latched), 0);

        for (int i = 0; i < 4; i++) begin
            step("gap_idle", 0, 0, 1, 0, 0);
            step("gap_valid", 1, 0, 1, 0, 0);
        end
        chk("gap_crit", int'(state_out), 3);

        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        repeat_step("prio_cold", 4, 1, 0, 1);
        chk("prio_cold_flag", int'(cold), 1);
        chk("prio_cold_events", int'(event_count), 1);
        repeat_step("prio_warn", 4, 1, 0, 0);
        chk("prio_warn_flag", int'(warn), 1);
        chk("prio_warn_events", int'(event_count), 1);
        repeat_step("prio_crit", 4, 0, 1, 0);
        chk("prio_crit_events", int'(event_count), 2);

        for (int i = 0; i < 5; i++) begin
            repeat_step("sat_ok", 4, 0, 0, 0);
            repeat_step("sat_crit", 4, 0, 1, 0);
        end
        chk("sat_events2", int'(event_count2), 3);
        chk("sat_events8", int'(event_count), 7);

        for (int blk = 0; blk < 120; blk++) begin
            bit th, ts, tl;
            int len;
            th = 1'($urandom); ts = ($urandom_range(0, 3) == 0); tl = 1'($urandom);
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++)
                step("rand", $urandom_range(0, 9) < 8, th, ts, tl, $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
